// File: rtl/uop_sequencer_if.sv
// Handshake and uOP bus between an issuing master and the micro-operation sequencer.
interface uop_sequencer_if;
  logic       START;
  logic [2:0] OPCODE;
  logic [1:0] ASRC;
  logic [1:0] BSRC;
  logic [4:0] uOP;
  logic       UOP_VALID;
  logic       BUSY;
  logic       DONE;

  modport master (
    output START, OPCODE, ASRC, BSRC,
    input  uOP, UOP_VALID, BUSY, DONE
  );

  modport slave (
    input  START, OPCODE, ASRC, BSRC,
    output uOP, UOP_VALID, BUSY, DONE
  );
endinterface

// File: rtl/uop_sequencer.sv
// Expands one macro operation per START handshake into a timed stream of 5-bit
// micro-operation codes, including the multi-cycle multiply hold.
module uop_sequencer #(
  parameter int unsigned MUL_CYCLES = 10,
  parameter logic [4:0]  IDLE_UOP   = 5'b00001
) (
  input logic            CLK,
  input logic            RST,
  uop_sequencer_if.slave bus
);

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_MUL_M   = 3'd3;
  localparam logic [2:0] S_MUL_Q   = 3'd4;
  localparam logic [2:0] S_MUL_RUN = 3'd5;
  localparam logic [2:0] S_FIN     = 3'd6;

  localparam logic [4:0] UOP_CLR  = 5'b00000;
  localparam logic [4:0] UOP_LDM  = 5'b00001;
  localparam logic [4:0] UOP_LDQ  = 5'b00010;
  localparam logic [4:0] UOP_MUL  = 5'b10110;
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [4:0] uop_q, uop_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] cnt_q, cnt_d;

  // Outputs are computed for the state being entered, so every output is a
  // plain flop and the first code of an operation lands on the accept edge.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    uop_d   = IDLE_UOP;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      S_INIT: state_d = S_IDLE;

      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (bus.START) begin
          valid_d = 1'b1;
          busy_d  = 1'b1;
          case (bus.OPCODE)
            3'b110: begin
              state_d = S_ISSUE;
              uop_d   = 5'd6 + {1'b0, bus.ASRC, bus.BSRC};
            end
            3'b111: begin
              state_d = S_MUL_M;
              uop_d   = UOP_LDM;
            end
            default: begin
              state_d = S_ISSUE;
              uop_d   = {2'b00, bus.OPCODE};
            end
          endcase
        end
      end

      S_ISSUE: begin
        state_d = S_FIN;
        done_d  = 1'b1;
      end

      S_MUL_M: begin
        state_d = S_MUL_Q;
        uop_d   = UOP_LDQ;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end

      S_MUL_Q: begin
        state_d = S_MUL_RUN;
        uop_d   = UOP_MUL;
        valid_d = 1'b1;
        busy_d  = 1'b1;
        cnt_d   = 4'd0;
      end

      S_MUL_RUN: begin
        if (cnt_q == MUL_LAST) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          uop_d   = UOP_MUL;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_INIT;
        uop_d   = UOP_CLR;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_INIT;
      uop_q   <= UOP_CLR;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      uop_q   <= uop_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.uOP       = uop_q;
  assign bus.UOP_VALID = valid_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;

endmodule

// File: tb/tb_uop_sequencer.sv
// Scoreboard bench for uop_sequencer: two instances (MUL_CYCLES=10 and 2) share
// stimulus; per-cycle expectations are queued and compared mid-cycle.
module tb_uop_sequencer;

  localparam logic [4:0] IDL  = 5'b00001;
  localparam logic [4:0] MULC = 5'b10110;

  logic clk;
  logic rst;
  int   cyc_cnt = 0;
  int   total   = 0;
  int   bad     = 0;

  uop_sequencer_if if0 ();
  uop_sequencer_if if1 ();

  uop_sequencer #(.MUL_CYCLES(10), .IDLE_UOP(5'b00001)) dut0 (
    .CLK(clk), .RST(rst), .bus(if0)
  );
  uop_sequencer #(.MUL_CYCLES(2), .IDLE_UOP(5'b00001)) dut1 (
    .CLK(clk), .RST(rst), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int         cyc;
    bit         sel;
    logic [4:0] uop;
    logic       v;
    logic       b;
    logic       d;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [4:0] mon_u;
  logic mon_v, mon_b, mon_d;

  // Mid-cycle monitor: pops every expectation due by the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      mon_e = sb.pop_front();
      if (mon_e.sel) begin
        mon_u = if1.uOP; mon_v = if1.UOP_VALID; mon_b = if1.BUSY; mon_d = if1.DONE;
      end else begin
        mon_u = if0.uOP; mon_v = if0.UOP_VALID; mon_b = if0.BUSY; mon_d = if0.DONE;
      end
      total++;
      if ({mon_u, mon_v, mon_b, mon_d} !== {mon_e.uop, mon_e.v, mon_e.b, mon_e.d}) begin
        bad++;
        $display("FAIL %s dut%0d cyc=%0d got uop=%b valid=%b busy=%b done=%b want uop=%b valid=%b busy=%b done=%b",
                 mon_e.tag, mon_e.sel, cyc_cnt, mon_u, mon_v, mon_b, mon_d,
                 mon_e.uop, mon_e.v, mon_e.b, mon_e.d);
      end
    end
  end

  task automatic drive(input logic st, input logic [2:0] op, input logic [1:0] a, input logic [1:0] bb);
    if0.START = st; if0.OPCODE = op; if0.ASRC = a; if0.BSRC = bb;
    if1.START = st; if1.OPCODE = op; if1.ASRC = a; if1.BSRC = bb;
  endtask

  // Drive inputs for one cycle and queue what the chosen DUT must show after the next edge.
  task automatic step(input logic st, input logic [2:0] op, input logic [1:0] a, input logic [1:0] bb,
                      input bit sel, input logic [4:0] eu, input logic ev, input logic eb,
                      input logic ed, input string tag);
    exp_t e;
    drive(st, op, a, bb);
    e.cyc = cyc_cnt + 1; e.sel = sel; e.uop = eu; e.v = ev; e.b = eb; e.d = ed; e.tag = tag;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    drive(1'b0, 3'b000, 2'b00, 2'b00);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, "reset_hold");
    rst = 1'b0;
    // The cycle just released shows INIT (checked by the last reset_hold entry); START must be ignored there.
    step(1'b1, 3'b110, 2'd2, 2'd3, 1'b0, IDL, 1'b0, 1'b0, 1'b0, "init_ignores_start");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, IDL, 1'b0, 1'b0, 1'b0, "idle_steady");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b1, IDL, 1'b0, 1'b0, 1'b0, "idle_steady_mul2");
  endtask

  task automatic test_alu;
    logic [1:0] av [3] = '{2'd2, 2'd0, 2'd3};
    logic [1:0] bv [3] = '{2'd3, 2'd0, 2'd3};
    logic [4:0] ev [3] = '{5'b10001, 5'b00110, 5'b10101};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b110, av[i], bv[i], 1'b0, ev[i], 1'b1, 1'b1, 1'b0, "alu_issue");
      step(1'b0, 3'b110, av[i], bv[i], 1'b0, IDL, 1'b0, 1'b0, 1'b1, "alu_fin");
      step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, IDL, 1'b0, 1'b0, 1'b0, "alu_idle");
    end
  endtask

  task automatic test_mul;
    step(1'b1, 3'b111, 2'd0, 2'd0, 1'b0, 5'b00001, 1'b1, 1'b1, 1'b0, "mul10_m");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 5'b00010, 1'b1, 1'b1, 1'b0, "mul10_q");
    for (int i = 0; i < 10; i++) step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, MULC, 1'b1, 1'b1, 1'b0, "mul10_run");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, IDL, 1'b0, 1'b0, 1'b1, "mul10_done");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, IDL, 1'b0, 1'b0, 1'b0, "mul10_after");

    step(1'b1, 3'b111, 2'd0, 2'd0, 1'b1, 5'b00001, 1'b1, 1'b1, 1'b0, "mul2_m");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b1, 5'b00010, 1'b1, 1'b1, 1'b0, "mul2_q");
    for (int i = 0; i < 2; i++) step(1'b0, 3'b000, 2'd0, 2'd0, 1'b1, MULC, 1'b1, 1'b1, 1'b0, "mul2_run");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b1, IDL, 1'b0, 1'b0, 1'b1, "mul2_done");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b1, IDL, 1'b0, 1'b0, 1'b0, "mul2_after");
    idle_cycles(10);
  endtask

  task automatic test_back_to_back;
    step(1'b1, 3'b101, 2'd0, 2'd0, 1'b0, 5'b00101, 1'b1, 1'b1, 1'b0, "b2b_shra");
    step(1'b1, 3'b011, 2'd0, 2'd0, 1'b0, IDL, 1'b0, 1'b0, 1'b1, "b2b_fin1");
    step(1'b1, 3'b011, 2'd0, 2'd0, 1'b0, 5'b00011, 1'b1, 1'b1, 1'b0, "b2b_shl");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, IDL, 1'b0, 1'b0, 1'b1, "b2b_fin2");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, IDL, 1'b0, 1'b0, 1'b0, "b2b_idle");
  endtask

  task automatic test_start_while_busy;
    step(1'b1, 3'b111, 2'd0, 2'd0, 1'b0, 5'b00001, 1'b1, 1'b1, 1'b0, "busy_m");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 5'b00010, 1'b1, 1'b1, 1'b0, "busy_q");
    for (int i = 1; i <= 10; i++)
      step(i == 5, 3'b001, 2'd0, 2'd0, 1'b0, MULC, 1'b1, 1'b1, 1'b0, "busy_run");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, IDL, 1'b0, 1'b0, 1'b1, "busy_done");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, IDL, 1'b0, 1'b0, 1'b0, "busy_no_ldm");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, IDL, 1'b0, 1'b0, 1'b0, "busy_no_ldm2");
  endtask

  task automatic test_async_reset;
    step(1'b1, 3'b111, 2'd0, 2'd0, 1'b0, 5'b00001, 1'b1, 1'b1, 1'b0, "abort_m");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 5'b00010, 1'b1, 1'b1, 1'b0, "abort_q");
    for (int i = 0; i < 4; i++) step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, MULC, 1'b1, 1'b1, 1'b0, "abort_run");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if ({if0.uOP, if0.UOP_VALID, if0.BUSY, if0.DONE} !== {5'b00000, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got uop=%b valid=%b busy=%b done=%b want uop=00000 valid=0 busy=0 done=0",
               if0.uOP, if0.UOP_VALID, if0.BUSY, if0.DONE);
    end
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, "abort_hold");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, "abort_hold");
    rst = 1'b0;
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, IDL, 1'b0, 1'b0, 1'b0, "recover_idle");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, IDL, 1'b0, 1'b0, 1'b0, "recover_idle2");
    step(1'b1, 3'b000, 2'd0, 2'd0, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b0, "clr_issue");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, IDL, 1'b0, 1'b0, 1'b1, "clr_fin");
    step(1'b0, 3'b000, 2'd0, 2'd0, 1'b0, IDL, 1'b0, 1'b0, 1'b0, "clr_idle");
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'b000, 2'd0, 2'd0);
    test_reset();
    test_alu();
    test_mul();
    test_back_to_back();
    test_start_while_busy();
    test_async_reset();
    repeat (2) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
